// File: rtl/altmemddr_ex_pkg.sv
// Shared constants and state type for the example-driver LFSR pattern sequencer.
package altmemddr_ex_pkg;

    localparam int LANE_W = 8;
    localparam logic [LANE_W-1:0] DEFAULT_SEED = 8'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/altmemddr_ex_lane_cmp.sv
// Single byte-lane comparator: flags a read byte that differs from the lane's pattern byte.
module altmemddr_ex_lane_cmp
    import altmemddr_ex_pkg::*;
(
    input  logic [LANE_W-1:0] expected,
    input  logic [LANE_W-1:0] actual,
    output logic              mismatch
);

    assign mismatch = (expected != actual);

endmodule

// File: rtl/altmemddr_ex_lfsr_seq.sv
// Drives the LFSR lane bank through write and read/compare passes and keeps
// per-pass error statistics for the example driver.
module altmemddr_ex_lfsr_seq
    import altmemddr_ex_pkg::*;
#(
    parameter int DATA_LANES = 4,
    parameter int BURST_W    = 8,
    parameter int ERR_W      = 16
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         is_read,
    input  logic                         use_seed,
    input  logic [LANE_W*DATA_LANES-1:0] seed_in,
    input  logic [BURST_W-1:0]           burst_len,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    input  logic                         rd_valid,
    input  logic [LANE_W*DATA_LANES-1:0] rd_data,
    output logic                         lfsr_enable,
    output logic                         lfsr_pause,
    output logic                         lfsr_load,
    output logic [LANE_W*DATA_LANES-1:0] lfsr_ldata,
    input  logic [LANE_W*DATA_LANES-1:0] lfsr_data,
    output logic [DATA_LANES-1:0]        err_lanes,
    output logic [ERR_W-1:0]             err_count,
    output logic [BURST_W-1:0]           first_err_beat
);

    seq_state_t           state;
    seq_state_t           next_state;
    logic                 is_read_q;
    logic [BURST_W-1:0]   burst_len_q;
    logic [BURST_W-1:0]   beat_cnt;
    logic                 beat;
    logic                 last_beat;
    logic [DATA_LANES-1:0] mismatch;

    for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
        altmemddr_ex_lane_cmp u_cmp (
            .expected (lfsr_data[i*LANE_W +: LANE_W]),
            .actual   (rd_data[i*LANE_W +: LANE_W]),
            .mismatch (mismatch[i])
        );
    end

    assign last_beat = (beat_cnt == burst_len_q - BURST_W'(1));

    // Pause follows the beat combinationally so a lane advances on the same edge its beat is taken.
    always_comb begin
        next_state  = state;
        busy        = 1'b1;
        done        = 1'b0;
        wr_valid    = 1'b0;
        lfsr_enable = 1'b1;
        lfsr_pause  = 1'b1;
        lfsr_load   = 1'b0;
        beat        = 1'b0;
        case (state)
            ST_IDLE: begin
                busy        = 1'b0;
                lfsr_enable = 1'b0;
                if (start) begin
                    if (burst_len == '0)
                        next_state = ST_DONE;
                    else if (use_seed)
                        next_state = ST_LOAD;
                    else
                        next_state = ST_RUN;
                end
            end
            ST_LOAD: begin
                lfsr_load  = 1'b1;
                next_state = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                wr_valid   = !is_read_q;
                beat       = is_read_q ? rd_valid : wr_ready;
                lfsr_pause = !beat;
                if (abort)
                    next_state = ST_IDLE;
                else if (beat && last_beat)
                    next_state = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                lfsr_enable = 1'b0;
                next_state  = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            is_read_q      <= 1'b0;
            burst_len_q    <= '0;
            beat_cnt       <= '0;
            lfsr_ldata     <= '0;
            err_lanes      <= '0;
            err_count      <= '0;
            first_err_beat <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && start) begin
                is_read_q      <= is_read;
                burst_len_q    <= burst_len;
                lfsr_ldata     <= seed_in;
                beat_cnt       <= '0;
                err_lanes      <= '0;
                err_count      <= '0;
                first_err_beat <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + BURST_W'(1);
                // First-failure index is latched only while no lane has failed yet.
                if (is_read_q && |mismatch) begin
                    err_lanes <= err_lanes | mismatch;
                    if (err_count != {ERR_W{1'b1}})
                        err_count <= err_count + ERR_W'(1);
                    if (err_lanes == '0)
                        first_err_beat <= beat_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_altmemddr_ex_lfsr_seq.sv
// Self-checking bench: emulated LFSR lanes feed the sequencer, a sequence-level model predicts data and errors.
module tb_altmemddr_ex_lfsr_seq;
    import altmemddr_ex_pkg::*;

    localparam int LANES = 4;
    localparam int BW    = 8;
    localparam int DW    = 8 * LANES;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            is_read = 1'b0;
    logic            use_seed = 1'b0;
    logic [DW-1:0]   seed_in = '0;
    logic [BW-1:0]   burst_len = '0;
    logic            abort = 1'b0;
    logic            wr_ready = 1'b0;
    logic            rd_valid = 1'b0;
    logic [DW-1:0]   rd_data = '0;
    logic [DW-1:0]   lfsr_data;

    logic            busy, done, wr_valid, lfsr_enable, lfsr_pause, lfsr_load;
    logic [DW-1:0]   lfsr_ldata;
    logic [LANES-1:0] err_lanes;
    logic [15:0]     err_count;
    logic [BW-1:0]   first_err_beat;

    logic            s_busy, s_done, s_wr_valid, s_enable, s_pause, s_load;
    logic [DW-1:0]   s_ldata;
    logic [LANES-1:0] s_err_lanes;
    logic [1:0]      s_err_count;
    logic [BW-1:0]   s_first_err_beat;

    int errors = 0;
    int checks = 0;

    logic [7:0] lane_q [LANES] = '{default: 8'h20};

    always #5 clk = ~clk;

    altmemddr_ex_lfsr_seq #(.DATA_LANES(LANES), .BURST_W(BW), .ERR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_read(is_read), .use_seed(use_seed),
        .seed_in(seed_in), .burst_len(burst_len), .abort(abort), .busy(busy), .done(done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .lfsr_enable(lfsr_enable), .lfsr_pause(lfsr_pause), .lfsr_load(lfsr_load),
        .lfsr_ldata(lfsr_ldata), .lfsr_data(lfsr_data), .err_lanes(err_lanes),
        .err_count(err_count), .first_err_beat(first_err_beat)
    );

    altmemddr_ex_lfsr_seq #(.DATA_LANES(LANES), .BURST_W(BW), .ERR_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .is_read(is_read), .use_seed(use_seed),
        .seed_in(seed_in), .burst_len(burst_len), .abort(abort), .busy(s_busy), .done(s_done),
        .wr_valid(s_wr_valid), .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .lfsr_enable(s_enable), .lfsr_pause(s_pause), .lfsr_load(s_load),
        .lfsr_ldata(s_ldata), .lfsr_data(lfsr_data), .err_lanes(s_err_lanes),
        .err_count(s_err_count), .first_err_beat(s_first_err_beat)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        logic [7:0] d;
        d = x << 1;
        return x[7] ? (d ^ 8'h1D) : d;
    endfunction

    // Behavioural stand-in for the altmemddr_ex_lfsr8 lanes, steered by the sequencer controls.
    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!lfsr_enable)
                lane_q[i] <= DEFAULT_SEED;
            else if (lfsr_load)
                lane_q[i] <= lfsr_ldata[i*8 +: 8];
            else if (!lfsr_pause)
                lane_q[i] <= lfsr_next(lane_q[i]);
        end
    end

    always_comb begin
        lfsr_data = '0;
        for (int i = 0; i < LANES; i++)
            lfsr_data[i*8 +: 8] = lane_q[i];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_wr_valid"}, wr_valid, 0);
        checkOutput({tag, "_load"}, lfsr_load, 0);
        checkOutput({tag, "_enable"}, lfsr_enable, 0);
        checkOutput({tag, "_pause"}, lfsr_pause, 1);
        checkOutput({tag, "_ldata"}, lfsr_ldata, 0);
        checkOutput({tag, "_err_lanes"}, err_lanes, 0);
        checkOutput({tag, "_err_count"}, err_count, 0);
        checkOutput({tag, "_first_err"}, first_err_beat, 0);
        checkOutput({tag, "_sat_count"}, s_err_count, 0);
    endtask

    // readyMode: 0 always ready, 1 pattern 1,0,0,1,1 then ready, 2 random.
    // corruptMode: 0 none, 1 lane 2 beat 2 bit flip, 2 every lane every beat, 3 random lanes.
    task automatic applyStimulus(input bit rd, input bit useSeed, input logic [31:0] seed,
                                 input int len, input int readyMode, input int corruptMode,
                                 input int abortAt);
        logic [7:0]       expv [LANES];
        logic [31:0]      expWord;
        logic [7:0]       c;
        logic [LANES-1:0] mLanes;
        logic [LANES-1:0] expErrLanes;
        int               expErrCnt, expFirst;
        int               cyc, beats, doneCnt, loadCnt, doneCyc, lastBeatCyc;
        bit               aborted, lost, rdy, beatNow;
        bit [4:0]         pattern;

        pattern = 5'b11001;
        for (int i = 0; i < LANES; i++)
            expv[i] = useSeed ? seed[i*8 +: 8] : DEFAULT_SEED;
        expErrLanes = '0;
        expErrCnt   = 0;
        expFirst    = 0;

        @(negedge clk);
        start     = 1'b1;
        is_read   = rd;
        use_seed  = useSeed;
        seed_in   = seed;
        burst_len = len[BW-1:0];
        abort     = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;

        cyc = 0; beats = 0; doneCnt = 0; loadCnt = 0; doneCyc = -1; lastBeatCyc = -1;
        aborted = 0; lost = 0;
        while (cyc < 3000 && doneCnt == 0 && !aborted && !lost) begin
            start     = 1'($urandom_range(0, 1));
            is_read   = 1'($urandom_range(0, 1));
            use_seed  = 1'($urandom_range(0, 1));
            burst_len = BW'($urandom);
            seed_in   = $urandom;
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc < 5) ? pattern[4 - cyc] : 1'b1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            wr_ready = rd ? 1'($urandom_range(0, 1)) : rdy;
            rd_valid = rd ? rdy : 1'($urandom_range(0, 1));
            mLanes   = '0;
            rd_data  = $urandom;
            if (rd && rd_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    case (corruptMode)
                        1:       c = (beats == 2 && i == 2) ? 8'h01 : 8'h00;
                        2:       c = 8'hFF;
                        3:       c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                        default: c = 8'h00;
                    endcase
                    rd_data[i*8 +: 8] = expv[i] ^ c;
                    mLanes[i] = (c != 8'h00);
                end
            end
            #1;
            if (lfsr_load) begin
                loadCnt++;
                checkOutput("load_pause", lfsr_pause, 1);
                checkOutput("load_enable", lfsr_enable, 1);
            end else if (done) begin
                doneCnt++;
                doneCyc = cyc;
                checkOutput("done_enable", lfsr_enable, 0);
                checkOutput("done_wr_valid", wr_valid, 0);
            end else if (lfsr_enable) begin
                beatNow = rd ? rd_valid : wr_ready;
                checkOutput("run_busy", busy, 1);
                checkOutput("run_wr_valid", wr_valid, !rd);
                checkOutput("run_pause", lfsr_pause, !beatNow);
                if (beatNow) begin
                    expWord = '0;
                    for (int i = 0; i < LANES; i++)
                        expWord[i*8 +: 8] = expv[i];
                    checkOutput(rd ? "rd_lane_data" : "wr_lane_data", lfsr_data, expWord);
                    if (|mLanes) begin
                        if (expErrLanes == '0)
                            expFirst = beats;
                        expErrLanes = expErrLanes | mLanes;
                        expErrCnt++;
                    end
                    for (int i = 0; i < LANES; i++)
                        expv[i] = lfsr_next(expv[i]);
                    lastBeatCyc = cyc;
                    if (beats == abortAt) begin
                        abort   = 1'b1;
                        aborted = 1;
                    end
                    beats++;
                end
            end else begin
                checkOutput("pass_active", lfsr_enable, 1);
                lost = 1;
            end
            @(negedge clk);
            cyc++;
        end
        abort    = 1'b0;
        start    = 1'b0;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        #1;
        checkOutput("after_busy", busy, 0);
        checkOutput("after_done", done, 0);
        checkOutput("load_cycles", loadCnt, (useSeed && len > 0) ? 1 : 0);
        if (!aborted) begin
            checkOutput("done_count", doneCnt, 1);
            checkOutput("beat_count", beats, len);
            checkOutput("done_latency", doneCyc, lastBeatCyc + 1);
        end
        checkOutput("ldata", lfsr_ldata, seed);
        checkOutput("err_lanes", err_lanes, expErrLanes);
        checkOutput("err_count", err_count, expErrCnt);
        checkOutput("first_err_beat", first_err_beat, expFirst);
        checkOutput("sat_err_lanes", s_err_lanes, expErrLanes);
        checkOutput("sat_err_count", s_err_count, (expErrCnt > 3) ? 3 : expErrCnt);
    endtask

    initial begin
        $display("[TB] starting");
        repeat (3) @(negedge clk);
        #1;
        checkResetValues("reset");
        reset_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'h0, 4, 0, 0, -1);
        applyStimulus(1'b0, 1'b0, 32'h0, 3, 1, 0, -1);
        applyStimulus(1'b1, 1'b0, 32'h0, 4, 0, 1, -1);
        checkOutput("directed_err_lanes", err_lanes, 4'b0100);
        checkOutput("directed_first_err", first_err_beat, 2);
        applyStimulus(1'b0, 1'b1, 32'h1D1D1D1D, 4, 0, 0, -1);
        applyStimulus(1'b1, 1'b0, 32'h0, 5, 0, 2, -1);
        checkOutput("saturated_count", s_err_count, 3);
        applyStimulus(1'b0, 1'b0, 32'h0, 8, 0, 0, 2);
        applyStimulus(1'b1, 1'b0, 32'h0, 6, 2, 3, 5);
        applyStimulus(1'b1, 1'b0, 32'h0, 6, 2, 2, 5);
        applyStimulus(1'b0, 1'b1, $urandom, 0, 0, 0, -1);
        applyStimulus(1'b0, 1'b0, 32'h0, 255, 0, 0, -1);

        for (int n = 0; n < 8; n++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          $urandom_range(1, 20), 2, 3,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1);

        // Reset in the middle of a pass abandons it without a done pulse.
        @(negedge clk);
        start = 1'b1; is_read = 1'b0; use_seed = 1'b1; seed_in = 32'hA5C3_1D77;
        burst_len = 8'd8; wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checkResetValues("midpass_reset");
        reset_n  = 1'b1;
        wr_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_reset_done", done, 0);
        checkOutput("post_reset_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/altmemddr_ex_lfsr_seq.md
Name: altmemddr_ex_lfsr_seq

Overview:
Sequencer for the example driver's bank of 8-bit LFSR pattern lanes (one altmemddr_ex_lfsr8 per byte lane).
- Write pass: drives enable, pause and load so each lane emits one pattern beat per accepted write beat.
- Read pass: replays the identical sequence and compares it against returning read data.
- Reports completion, sticky per-lane error flags, a saturating error count and the first failing beat index.
- Sits between the example driver's test FSM and the LFSR lanes / local-interface data path.

Parameters:
- DATA_LANES, 4, number of 8-bit LFSR lanes (data width = 8*DATA_LANES).
- BURST_W, 8, width of burst_len and beat counters.
- ERR_W, 16, width of err_count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  pass request, sampled only in IDLE.
- is_read  in  1  sampled with start: 1 = read/compare pass, 0 = write pass.
- use_seed  in  1  sampled with start: 1 = load seed_in before first beat.
- seed_in  in  8*DATA_LANES  per-lane load value.
- burst_len  in  BURST_W  beats in the pass, sampled with start.
- abort  in  1  terminate pass, return to IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- wr_valid  out  1  write beat valid (data = lfsr_data).
- wr_ready  in  1  write beat accepted.
- rd_valid  in  1  read beat present on rd_data.
- rd_data  in  8*DATA_LANES  read data for compare.
- lfsr_enable  out  1  to all lanes; low forces lanes to seed.
- lfsr_pause  out  1  to all lanes; high holds lane state.
- lfsr_load  out  1  to all lanes; high loads lfsr_ldata.
- lfsr_ldata  out  8*DATA_LANES  load data (registered copy of seed_in).
- lfsr_data  in  8*DATA_LANES  current lane outputs.
- err_lanes  out  DATA_LANES  sticky per-lane mismatch flags.
- err_count  out  ERR_W  mismatching beats, saturating.
- first_err_beat  out  BURST_W  beat index of first mismatch; valid when |err_lanes.

Behaviour:
Reset (reset_n low at a clk edge):
- State IDLE; busy, done, wr_valid, lfsr_load = 0; lfsr_enable = 0; lfsr_pause = 1.
- err_lanes, err_count, first_err_beat, lfsr_ldata, beat counter = 0.
- Reset mid-pass abandons the pass; no done pulse.

State IDLE:
- lfsr_enable = 0, so lanes sit at seed.
- On start: capture is_read, burst_len, and seed_in into lfsr_ldata; clear err_lanes, err_count, first_err_beat and the beat counter.
- Next state: burst_len == 0 -> DONE; use_seed -> LOAD; otherwise RUN.

State LOAD:
- Exactly one cycle with lfsr_enable = 1, lfsr_load = 1, lfsr_pause = 1; then RUN.

State RUN:
- lfsr_enable = 1, lfsr_load = 0.
- Write pass: wr_valid = 1. Beat = wr_valid & wr_ready. lfsr_pause = !beat (combinational), so the lane advances in the same edge the beat is accepted. rd_valid is ignored.
- Read pass: wr_valid = 0. Beat = rd_valid. lfsr_pause = !rd_valid. wr_ready is ignored.
- Compare on each read beat, per lane i: mismatch_i = rd_data[8i+7:8i] != lfsr_data[8i+7:8i].
  - Any mismatch_i: set err_lanes[i] (sticky); increment err_count, saturating at all-ones.
  - If no prior error: first_err_beat = current beat index.
- Beat counter increments per beat, starting at 0. The beat with index burst_len-1 moves the FSM to DONE.

State DONE:
- done = 1 for one cycle; lfsr_enable = 0 (lanes reseed); wr_valid = 0; then IDLE.
- busy drops the cycle after done.

Boundary and simultaneous-event rules:
- abort in LOAD/RUN: next state IDLE, no done pulse, error state retained. abort beats a same-cycle final beat (that beat is still counted and compared).
- start while busy: ignored.
- abort in IDLE or DONE: no effect.
- burst_len = 2^BURST_W-1 is the maximum pass length.
- Write data is not driven by this block; lfsr_data is wired directly to the write path.

Latency: with use_seed = 0, the first beat can occur 1 cycle after start; with use_seed = 1, 2 cycles after start.

Decomposition:
Shared package altmemddr_ex_pkg holds:
- state encoding constants (IDLE, LOAD, RUN, DONE);
- the default lane seed (32);
- LANE_W = 8.

One sub-module is natural: altmemddr_ex_lane_cmp. It is a per-lane registered-free comparator producing mismatch_i, instantiated DATA_LANES times. The FSM, counters and error logic stay in the top module.

Test Plan:
- Write pass, burst_len=4, use_seed=0, wr_ready always 1 -> lane 0 outputs 0x20,0x40,0x80,0x1D on accepted beats; done pulses once; busy low afterward.
- Write pass, burst_len=3, wr_ready pattern 1,0,0,1,1 -> lfsr_pause high on the ready=0 cycles; lane 0 values 0x20,0x40,0x80; done after the 5th cycle.
- Read pass, burst_len=4, rd_data = expected sequence with lane 2 beat 2 corrupted (0x80 -> 0x81) -> err_lanes=4'b0100, err_count=1, first_err_beat=2.
- use_seed=1, seed_in lanes = 0x1D -> LOAD lasts one cycle; the first beat on lane 0 is 0x1D, the next is 0x3A.
- Read pass, ERR_W=2 override, 5 fully mismatching beats -> err_count saturates at 3; err_lanes all 1; first_err_beat=0.
- abort in RUN at beat 2 of 8, then reset_n low mid-pass in a second run -> no done pulse in either case; busy=0 next cycle; after reset all outputs at reset values and lfsr_enable=0.
